// File: rtl/rv32e_uart_boot_rom.sv
// rv32e_uart_boot_rom
//   Program store for the rv32e_soc instruction port. After reset the SoC is
//   held in reset while a program image arrives over a UART RX line (8N1,
//   LSB first). The image is a 16-bit little-endian word count followed by
//   that many 32-bit words, each sent least significant byte first. When the
//   last word has been written the SoC is released and instruction words are
//   served combinationally from program_addr_bus.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   ADDR_WIDTH    word-address width; the store holds 2**ADDR_WIDTH words
//
// Ports
//   clk               in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   rx                in   UART serial input, idles high, asynchronous to clk
//   program_addr_bus  in   32-bit byte address from the CPU
//   program_data_bus  out  32-bit instruction word, combinational
//   soc_reset         out  holds the SoC in reset until the image is loaded
//   loading           out  high while the loader is waiting for image bytes
//   load_error        out  sticky framing / bad-length flag

module rv32e_uart_boot_rom #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [31:0] program_addr_bus,
  output logic [31:0] program_data_bus,
  output logic        soc_reset,
  output logic        loading,
  output logic        load_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, RUN} load_state_t;

  rx_state_t   rx_state;
  load_state_t load_state;

  logic                  rx_meta;
  logic                  rx_sync;
  logic [CNT_W-1:0]      clk_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic                  byte_valid;
  logic                  frame_err;
  logic                  wait_high;

  logic [15:0]           len;
  logic [15:0]           new_len;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_hit;
  logic                  addr_unused;

  // Two-flop synchronizer; flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // UART receiver. The start bit is re-checked at mid-bit to reject glitches;
  // every later sample lands one bit period after the previous one. A bad
  // stop bit raises frame_err once and then parks in STOP until the line
  // returns high, so a line stuck low produces a single error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      wait_high  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_MAX) begin
            clk_cnt  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_BITS;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_BITS: begin
          if (clk_cnt == FULL_MAX) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (wait_high) begin
            if (rx_sync) begin
              wait_high <= 1'b0;
              rx_state  <= RX_IDLE;
            end
          end else if (clk_cnt == FULL_MAX) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              wait_high <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Candidate length formed from the stored low byte and the byte in flight.
  assign new_len = {shift_reg, len[7:0]};

  // The final byte of each word goes straight into memory together with the
  // three bytes buffered before it.
  always_comb begin
    mem_we    = byte_valid && (load_state == DATA) && (byte_idx == 2'd3);
    mem_waddr = word_cnt[ADDR_WIDTH-1:0];
    mem_wdata = {shift_reg, word_buf};
  end

  // Image loader. Once in RUN it ignores the receiver entirely, so only a
  // reset can start another load. soc_reset and loading drop on the same edge
  // that commits the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_state <= LEN_LO;
      soc_reset  <= 1'b1;
      loading    <= 1'b1;
      load_error <= 1'b0;
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else if (load_state != RUN) begin
      if (frame_err) begin
        load_error <= 1'b1;
        load_state <= LEN_LO;
      end else if (byte_valid) begin
        case (load_state)
          LEN_LO: begin
            len[7:0]   <= shift_reg;
            load_state <= LEN_HI;
          end
          LEN_HI: begin
            len[15:8] <= shift_reg;
            if ((new_len == 16'd0) || ({1'b0, new_len} > 17'(DEPTH))) begin
              load_error <= 1'b1;
              load_state <= LEN_LO;
            end else begin
              word_cnt   <= '0;
              byte_idx   <= '0;
              load_state <= DATA;
            end
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= shift_reg;
              2'd1: word_buf[15:8]  <= shift_reg;
              2'd2: word_buf[23:16] <= shift_reg;
              default: begin
                word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
                if (17'(word_cnt) + 17'd1 == {1'b0, len}) begin
                  load_state <= RUN;
                  soc_reset  <= 1'b0;
                  loading    <= 1'b0;
                end
              end
            endcase
          end
          default: load_state <= load_state;
        endcase
      end
    end
  end

  // Program memory has no reset: stale words survive a reset but stay hidden
  // because the read port treats the loaded count as zero until RUN.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_idx      = program_addr_bus[ADDR_WIDTH+1:2];
  assign addr_unused = ^program_addr_bus[1:0];

  // Anything outside the loaded image, including every address while
  // loading, fetches a NOP.
  always_comb begin
    rd_hit = (program_addr_bus[31:ADDR_WIDTH+2] == '0) && !loading &&
             (17'(rd_idx) < {1'b0, len});
    program_data_bus = rd_hit ? mem[rd_idx] : NOP_WORD;
  end

endmodule
